popcount8_enum: RTL and testbench
=================================

POPCOUNT8_ENUM -- requirements
Module: popcount8_enum

Interface
REQ-001 SHALL have parameter N, default 8, meaning word width; supported range 1..16.
REQ-002 SHALL have port CLK, input, 1, sole clock, all state on rising edge.
REQ-003 SHALL have port RESET, input, 1, reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port K_valid, input, 1, request K is valid.
REQ-005 SHALL have port K, input, $clog2(N+1) (4 at N=8), requested popcount.
REQ-006 SHALL have port K_ready, output, 1, block accepts a request.
REQ-007 SHALL have port O, output, N, current enumerated word.
REQ-008 SHALL have port O_valid, output, 1, O is valid.
REQ-009 SHALL have port O_ready, input, 1, consumer accepts O.
REQ-010 SHALL have port O_last, output, 1, O is final word of the sequence.
REQ-011 SHALL have port IDX, output, 16, zero-based index of O within the sequence.
REQ-012 SHALL have port ERR, output, 1, one-cycle pulse on an out-of-range request.

Function
REQ-013 SHALL, per accepted K, emit every N-bit word with popcount == K exactly once, strictly ascending: C(N,K) words (28 for K=2, 70 for K=4 at N=8).
REQ-014 SHALL implement FSM states IDLE and RUN.
REQ-015 In IDLE: K_ready=1, O_valid=0; request accepted on K_valid & K_ready.
REQ-016 On accept with 1<=K<=N: load v=(1<<K)-1, IDX=0, enter RUN; O_valid SHALL rise the cycle after accept (latency 1).
REQ-017 On accept with K==0: enter RUN with v=0, O_last=1; exactly one word 0x00.
REQ-018 On accept with K>N: stay IDLE, K_ready stays 1, ERR=1 for exactly one cycle, no O_valid.
REQ-019 In RUN: K_ready=0, O_valid=1, O=v; K_valid SHALL be ignored.
REQ-020 O_last SHALL be 1 iff v == ((1<<K)-1)<<(N-K) (K==N: single word all-ones, O_last=1).
REQ-021 On O_valid & O_ready & !O_last: v <= next combination (Gosper: t=v|(v-1); next=(t+1)|(((~t & (t+1))-1) >> (ctz(v)+1))), IDX <= IDX+1.
REQ-022 Gosper intermediates SHALL be N+1 bits wide; result masked to N bits; ctz evaluated only for v!=0.
REQ-023 On O_valid & O_ready & O_last: return to IDLE; K_ready=1 the next cycle, O_valid=0.
REQ-024 While O_valid & !O_ready: O, O_last, IDX SHALL hold stable.
REQ-025 With O_ready held high, SHALL sustain one word per cycle, no bubbles.
REQ-026 Latched K SHALL be unaffected by K changes during RUN.

Reset
REQ-027 While RESET=1 at a rising edge: state<=IDLE, O_valid=0, O=0, O_last=0, IDX=0, ERR=0, K_ready=0 while RESET is high.
REQ-028 K_ready SHALL be 1 the first cycle after RESET deasserts.
REQ-029 RESET during RUN SHALL abort the sequence; no further words from the aborted request.

Verification
REQ-030 K=0 -> one word O=0x00, O_last=1, IDX=0; K_ready=1 next cycle.
REQ-031 K=2, O_ready=1 -> 28 back-to-back words 0x03,0x05,0x06,0x09,...,0xC0; IDX 0..27; O_last only on 0xC0.
REQ-032 K=8 -> single word 0xFF with O_last=1; K=9 -> ERR pulse one cycle, O_valid stays 0, K_ready stays 1.
REQ-033 K=4 with random O_ready stalls -> 70 words, each popcount 4, strictly ascending, stable during stalls, last 0xF0 at IDX=69.
REQ-034 K=3, RESET pulsed after 5 handshakes -> O_valid=0 the cycle after reset; then K=1 -> 0x01,0x02,...,0x80, IDX restarting at 0.
REQ-035 K_valid held high with changing K during RUN -> no second accept; sequence completes for original K only.

Source files
------------

// File: rtl/popcount8_enum.sv
// Enumerates every N-bit word with popcount K, in ascending order, one word per O handshake.
// Latency: the first word is valid the cycle after a request is accepted; one word per cycle when O_ready stays high.
// Backpressure: O, O_last and IDX hold while O_ready is low; K_ready is low during a sequence and while RESET is high.
module popcount8_enum #(
    parameter  int N  = 8,
    localparam int KW = $clog2(N + 1)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          K_valid,
    input  logic [KW-1:0] K,
    output logic          K_ready,
    output logic [N-1:0]  O,
    output logic          O_valid,
    input  logic          O_ready,
    output logic          O_last,
    output logic [15:0]   IDX,
    output logic          ERR
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [N:0] ONE = (N + 1)'(1);

    state_t        state_q, state_d;
    logic [N-1:0]  v_q, v_d;
    logic [KW-1:0] k_q, k_d;
    logic [15:0]   idx_q, idx_d;
    logic          err_q, err_d;

    logic [N-1:0]  last_w;
    logic [N-1:0]  init_w;
    logic [N-1:0]  v_next;
    logic [N:0]    g_v, g_t, g_t1, g_u, g_nxt;
    logic [4:0]    ctz;
    logic          is_last;

    // Reference words: the final (top-packed) word for the latched K, and the first word for an incoming K.
    always_comb begin
        last_w = '0;
        init_w = '0;
        for (int i = 0; i < N; i++) begin
            last_w[i] = (i >= N - int'(k_q));
            init_w[i] = (i < int'(K));
        end
    end

    // Next combination by Gosper's hack; one spare top bit absorbs the carry out of t+1.
    always_comb begin
        ctz = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v_q[i]) begin
                ctz = 5'(i);
            end
        end
        g_v   = {1'b0, v_q};
        g_t   = g_v | (g_v - ONE);
        g_t1  = g_t + ONE;
        g_u   = (~g_t & g_t1) - ONE;
        g_nxt = g_t1 | (g_u >> (ctz + 5'd1));
        // The zero word (K==0) has no lowest set bit and is always the only word.
        if (v_q == '0) begin
            g_nxt = '0;
        end
        v_next = N'(g_nxt);
    end

    assign is_last = (v_q == last_w);

    // Next-state logic: request accept/reject in IDLE, word stepping on handshakes in RUN.
    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        k_d     = k_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (K_valid) begin
                    if (int'(K) > N) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        k_d     = K;
                        v_d     = init_w;
                        idx_d   = '0;
                    end
                end
            end
            RUN: begin
                if (O_ready) begin
                    if (is_last) begin
                        state_d = IDLE;
                    end else begin
                        v_d   = v_next;
                        idx_d = idx_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset; reset aborts any sequence in flight.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            v_q     <= '0;
            k_q     <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            k_q     <= k_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    assign K_ready = (state_q == IDLE) && !RESET;
    assign O_valid = (state_q == RUN);
    assign O       = (state_q == RUN) ? v_q : '0;
    assign O_last  = (state_q == RUN) && is_last;
    assign IDX     = idx_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_popcount8_enum.sv
// Scoreboard bench for popcount8_enum at N=8: expected words queued at request time, checked by a monitor.
// Latency: the monitor samples on the falling edge; a word is popped whenever O_valid and O_ready are both high.
// Backpressure: O_ready is driven high, low, or randomly by a dedicated process selected with rdy_mode.
module tb_popcount8_enum;

    logic        CLK;
    logic        RESET;
    logic        K_valid;
    logic [3:0]  K;
    logic        K_ready;
    logic [7:0]  O;
    logic        O_valid;
    logic        O_ready;
    logic        O_last;
    logic [15:0] IDX;
    logic        ERR;

    typedef struct {
        logic [7:0]  o;
        logic        last;
        logic [15:0] idx;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   npop   = 0;
    int   rdy_mode = 1;   // 0: low, 1: high, 2: random

    popcount8_enum #(.N(8)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .K_valid (K_valid),
        .K       (K),
        .K_ready (K_ready),
        .O       (O),
        .O_valid (O_valid),
        .O_ready (O_ready),
        .O_last  (O_last),
        .IDX     (IDX),
        .ERR     (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference sequence by exhaustive ascending scan with a popcount filter.
    task automatic push_model(input int k);
        int total = 0;
        int n = 0;
        exp_t e;
        for (int w = 0; w < 256; w++) if ($countones(w) == k) total++;
        for (int w = 0; w < 256; w++) begin
            if ($countones(w) == k) begin
                e.o = 8'(w);
                e.idx = 16'(n);
                e.last = (n == total - 1);
                q.push_back(e);
                n++;
            end
        end
    endtask

    // Consumer readiness, changed well away from both clock edges.
    always @(posedge CLK) begin
        #2;
        case (rdy_mode)
            0:       O_ready = 1'b0;
            1:       O_ready = 1'b1;
            default: O_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: pop and compare on each handshake; check stability across stalls.
    logic        held_vld = 1'b0;
    logic [7:0]  held_o;
    logic        held_last;
    logic [15:0] held_idx;
    always @(negedge CLK) begin
        exp_t e;
        if (held_vld && O_valid) begin
            chk("stall_O", 32'(O), 32'(held_o));
            chk("stall_last", 32'(O_last), 32'(held_last));
            chk("stall_IDX", 32'(IDX), 32'(held_idx));
        end
        held_vld  = O_valid && !O_ready;
        held_o    = O;
        held_last = O_last;
        held_idx  = IDX;
        if (O_valid && O_ready) begin
            npop++;
            if (q.size() == 0) begin
                chk("unexpected_word", 32'(O), 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("word_O", 32'(O), 32'(e.o));
                chk("word_IDX", 32'(IDX), 32'(e.idx));
                chk("word_last", 32'(O_last), 32'(e.last));
            end
        end
    end

    task automatic send_k(input logic [3:0] k);
        @(posedge CLK);
        #1;
        K_valid = 1'b1;
        K = k;
        @(posedge CLK);
        #1;
        K_valid = 1'b0;
    endtask

    // Wait for the last expected word to be consumed, then check the return to IDLE.
    task automatic wait_drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge CLK);
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
        @(negedge CLK);
        chk("idle_K_ready", 32'(K_ready), 32'd1);
        chk("idle_O_valid", 32'(O_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] k2_tab [28];
        exp_t e;
        int bubbles;
        int n;
        k2_tab = '{8'h03, 8'h05, 8'h06, 8'h09, 8'h0A, 8'h0C, 8'h11, 8'h12, 8'h14, 8'h18,
                   8'h21, 8'h22, 8'h24, 8'h28, 8'h30, 8'h41, 8'h42, 8'h44, 8'h48, 8'h50,
                   8'h60, 8'h81, 8'h82, 8'h84, 8'h88, 8'h90, 8'hA0, 8'hC0};
        RESET   = 1'b1;
        K_valid = 1'b0;
        K       = '0;
        O_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_K_ready", 32'(K_ready), 32'd0);
        chk("rst_O_valid", 32'(O_valid), 32'd0);
        chk("rst_O", 32'(O), 32'd0);
        chk("rst_O_last", 32'(O_last), 32'd0);
        chk("rst_IDX", 32'(IDX), 32'd0);
        chk("rst_ERR", 32'(ERR), 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        chk("post_rst_K_ready", 32'(K_ready), 32'd1);

        // K=0: single zero word
        e.o = 8'h00; e.last = 1'b1; e.idx = 16'd0;
        q.push_back(e);
        send_k(4'd0);
        @(negedge CLK);
        chk("k0_latency_O_valid", 32'(O_valid), 32'd1);
        wait_drain(50);

        // K=9: rejected with a one-cycle ERR pulse
        send_k(4'd9);
        @(negedge CLK);
        chk("k9_ERR", 32'(ERR), 32'd1);
        chk("k9_O_valid", 32'(O_valid), 32'd0);
        chk("k9_K_ready", 32'(K_ready), 32'd1);
        @(negedge CLK);
        chk("k9_ERR_drop", 32'(ERR), 32'd0);
        chk("k9_O_valid2", 32'(O_valid), 32'd0);

        // K=8: single all-ones word
        push_model(8);
        send_k(4'd8);
        wait_drain(50);

        // K=2 back-to-back, hand table
        for (int i = 0; i < 28; i++) begin
            e.o = k2_tab[i]; e.idx = 16'(i); e.last = (i == 27);
            q.push_back(e);
        end
        send_k(4'd2);
        bubbles = 0;
        for (int i = 0; i < 28; i++) begin
            @(negedge CLK);
            if (!O_valid) bubbles++;
        end
        chk("k2_bubbles", 32'(bubbles), 32'd0);
        wait_drain(50);

        // K=4 under random stalls
        rdy_mode = 2;
        push_model(4);
        send_k(4'd4);
        wait_drain(2000);
        rdy_mode = 1;

        // K=3 aborted by reset after five handshakes
        push_model(3);
        n = npop + 5;
        send_k(4'd3);
        for (int i = 0; i < 100 && npop < n; i++) @(negedge CLK);
        chk("k3_five_pops", 32'(npop), 32'(n));
        rdy_mode = 0;
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        q.delete();
        @(negedge CLK);
        chk("k3_abort_O_valid", 32'(O_valid), 32'd0);
        chk("k3_abort_K_ready", 32'(K_ready), 32'd1);
        rdy_mode = 1;
        repeat (3) @(negedge CLK);
        chk("k3_no_more_words", 32'(O_valid), 32'd0);

        // K=1 after the abort: IDX restarts at 0
        push_model(1);
        send_k(4'd1);
        wait_drain(50);

        // K=5 with K_valid held high and K changing during the sequence
        push_model(5);
        @(posedge CLK);
        #1;
        K_valid = 1'b1;
        K = 4'd5;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            #1;
            K = 4'((i * 3 + 1) % 10);
            @(negedge CLK);
            if (i == 4) chk("k5_K_ready_run", 32'(K_ready), 32'd0);
        end
        K_valid = 1'b0;
        wait_drain(200);

        repeat (5) @(negedge CLK);
        chk("final_queue_empty", 32'(q.size()), 32'd0);
        chk("final_O_valid", 32'(O_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
